man_move_ctrl: RTL and testbench

- Player-movement controller for the Sokoban core. Accepts one direction request at a time and checks the 8x8 level map in the external map RAM. Moves the player, pushing a box when legal, and writes the box move back to the map.
- Produces the 6-bit player cell index `man` = {row[2:0], col[2:0]}, which the man sprite layer consumes directly. Also produces the step/push counters for the HUD.

---
 rtl/man_move_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_man_move_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/man_move_ctrl.sv
// rtl/man_move_ctrl.sv - Sokoban player-movement controller: map reads, box push write-back, HUD counters.
// Defining MAN_UNDO_EN adds undo_req and single-level undo of the last completed move.
module man_move_ctrl #(
  parameter logic [5:0] START_POS = 6'd9,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [5:0]       load_pos,
  input  logic             move_req,
  input  logic [1:0]       move_dir,
`ifdef MAN_UNDO_EN
  input  logic             undo_req,
`endif
  output logic             busy,
  output logic             move_done,
  output logic             moved,
  output logic             pushed,
  output logic [5:0]       man,
  output logic [CNT_W-1:0] step_cnt,
  output logic [CNT_W-1:0] push_cnt,
  output logic [5:0]       map_addr,
  output logic             map_rd_en,
  input  logic [1:0]       map_rdata,
  output logic             map_wr_en,
  output logic [1:0]       map_wdata
);

  typedef enum logic [3:0] {
    IDLE, RD1, CHK1, RD2, CHK2, WR_BOX, WR_CLR
`ifdef MAN_UNDO_EN
    , UNDO_CLR, UNDO_BOX
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [5:0]       cell_n, cell_n_d;
  logic [5:0]       cell_b, cell_b_d;
  logic [5:0]       man_d;
  logic [CNT_W-1:0] step_d, push_d;
  logic             busy_d, done_d, moved_d, pushed_d;
  logic [5:0]       addr_d;
  logic             rd_en_d, wr_en_d;
  logic [1:0]       wdata_d;
  logic             fin, fin_moved, fin_pushed;

`ifdef MAN_UNDO_EN
  logic             rec_valid, rec_valid_d;
  logic             rec_pushed, rec_pushed_d;
  logic [5:0]       rec_prev, rec_prev_d;
  logic [5:0]       rec_b, rec_b_d;
`endif

  function automatic logic off_grid(input logic [5:0] pos, input logic [1:0] dir);
    case (dir)
      2'd0:    off_grid = (pos[5:3] == 3'd0);
      2'd1:    off_grid = (pos[5:3] == 3'd7);
      2'd2:    off_grid = (pos[2:0] == 3'd0);
      default: off_grid = (pos[2:0] == 3'd7);
    endcase
  endfunction

  function automatic logic [5:0] neighbour(input logic [5:0] pos, input logic [1:0] dir);
    case (dir)
      2'd0:    neighbour = {pos[5:3] - 3'd1, pos[2:0]};
      2'd1:    neighbour = {pos[5:3] + 3'd1, pos[2:0]};
      2'd2:    neighbour = {pos[5:3], pos[2:0] - 3'd1};
      default: neighbour = {pos[5:3], pos[2:0] + 3'd1};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

`ifdef MAN_UNDO_EN
  function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] v);
    dec_floor = (v == '0) ? v : v - CNT_ONE;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= 2'd0;
      cell_n    <= 6'd0;
      cell_b    <= 6'd0;
      man       <= START_POS;
      step_cnt  <= '0;
      push_cnt  <= '0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      moved     <= 1'b0;
      pushed    <= 1'b0;
      map_addr  <= 6'd0;
      map_rd_en <= 1'b0;
      map_wr_en <= 1'b0;
      map_wdata <= 2'b00;
`ifdef MAN_UNDO_EN
      rec_valid  <= 1'b0;
      rec_pushed <= 1'b0;
      rec_prev   <= 6'd0;
      rec_b      <= 6'd0;
`endif
    end else begin
      state     <= state_d;
      dir_q     <= dir_d;
      cell_n    <= cell_n_d;
      cell_b    <= cell_b_d;
      man       <= man_d;
      step_cnt  <= step_d;
      push_cnt  <= push_d;
      busy      <= busy_d;
      move_done <= done_d;
      moved     <= moved_d;
      pushed    <= pushed_d;
      map_addr  <= addr_d;
      map_rd_en <= rd_en_d;
      map_wr_en <= wr_en_d;
      map_wdata <= wdata_d;
`ifdef MAN_UNDO_EN
      rec_valid  <= rec_valid_d;
      rec_pushed <= rec_pushed_d;
      rec_prev   <= rec_prev_d;
      rec_b      <= rec_b_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    dir_d      = dir_q;
    cell_n_d   = cell_n;
    cell_b_d   = cell_b;
    man_d      = man;
    step_d     = step_cnt;
    push_d     = push_cnt;
    busy_d     = busy;
    done_d     = 1'b0;
    moved_d    = 1'b0;
    pushed_d   = 1'b0;
    addr_d     = map_addr;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    wdata_d    = map_wdata;
    fin        = 1'b0;
    fin_moved  = 1'b0;
    fin_pushed = 1'b0;
`ifdef MAN_UNDO_EN
    rec_valid_d  = rec_valid;
    rec_pushed_d = rec_pushed;
    rec_prev_d   = rec_prev;
    rec_b_d      = rec_b;
`endif

    // load pre-empts everything; strobes fall back to their idle defaults
    if (load) begin
      state_d = IDLE;
      man_d   = load_pos;
      step_d  = '0;
      push_d  = '0;
      busy_d  = 1'b0;
`ifdef MAN_UNDO_EN
      rec_valid_d = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (move_req) begin
            dir_d = move_dir;
            if (off_grid(man, move_dir)) begin
              fin = 1'b1;
            end else begin
              cell_n_d = neighbour(man, move_dir);
              addr_d   = neighbour(man, move_dir);
              rd_en_d  = 1'b1;
              busy_d   = 1'b1;
              state_d  = RD1;
            end
          end
`ifdef MAN_UNDO_EN
          else if (undo_req && rec_valid) begin
            if (rec_pushed) begin
              addr_d  = rec_b;
              wr_en_d = 1'b1;
              wdata_d = 2'b00;
              busy_d  = 1'b1;
              state_d = UNDO_CLR;
            end else begin
              man_d       = rec_prev;
              done_d      = 1'b1;
              moved_d     = 1'b1;
              step_d      = dec_floor(step_cnt);
              rec_valid_d = 1'b0;
            end
          end
`endif
        end
        RD1: state_d = CHK1;
        CHK1: begin
          case (map_rdata)
            2'b00: begin
              man_d     = cell_n;
              fin       = 1'b1;
              fin_moved = 1'b1;
            end
            2'b10: begin
              if (off_grid(cell_n, dir_q)) begin
                fin = 1'b1;
              end else begin
                cell_b_d = neighbour(cell_n, dir_q);
                addr_d   = neighbour(cell_n, dir_q);
                rd_en_d  = 1'b1;
                state_d  = RD2;
              end
            end
            default: fin = 1'b1;
          endcase
        end
        RD2: state_d = CHK2;
        CHK2: begin
          if (map_rdata == 2'b00) begin
            addr_d  = cell_b;
            wr_en_d = 1'b1;
            wdata_d = 2'b10;
            state_d = WR_BOX;
          end else begin
            fin = 1'b1;
          end
        end
        WR_BOX: begin
          addr_d  = cell_n;
          wr_en_d = 1'b1;
          wdata_d = 2'b00;
          state_d = WR_CLR;
        end
        WR_CLR: begin
          man_d      = cell_n;
          fin        = 1'b1;
          fin_moved  = 1'b1;
          fin_pushed = 1'b1;
        end
`ifdef MAN_UNDO_EN
        // box goes back from B to N (the player's current cell)
        UNDO_CLR: begin
          addr_d  = man;
          wr_en_d = 1'b1;
          wdata_d = 2'b10;
          state_d = UNDO_BOX;
        end
        UNDO_BOX: begin
          man_d       = rec_prev;
          done_d      = 1'b1;
          moved_d     = 1'b1;
          pushed_d    = 1'b1;
          busy_d      = 1'b0;
          step_d      = dec_floor(step_cnt);
          push_d      = dec_floor(push_cnt);
          rec_valid_d = 1'b0;
          state_d     = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase

      if (fin) begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
        moved_d  = fin_moved;
        pushed_d = fin_pushed;
        if (fin_moved)  step_d = sat_inc(step_cnt);
        if (fin_pushed) push_d = sat_inc(push_cnt);
`ifdef MAN_UNDO_EN
        if (fin_moved) begin
          rec_valid_d  = 1'b1;
          rec_prev_d   = man;
          rec_pushed_d = fin_pushed;
          rec_b_d      = cell_b;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_man_move_ctrl.sv
// tb/tb_man_move_ctrl.sv - Directed bench for man_move_ctrl against a cell-level map/move model.
// Undo cases are compiled in when MAN_UNDO_EN is defined.
`timescale 1ns/1ps
module tb_man_move_ctrl;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, load, move_req;
  logic [5:0]       load_pos;
  logic [1:0]       move_dir;
`ifdef MAN_UNDO_EN
  logic             undo_req;
`endif
  logic             busy, move_done, moved, pushed;
  logic [5:0]       man, map_addr;
  logic [CNT_W-1:0] step_cnt, push_cnt;
  logic             map_rd_en, map_wr_en;
  logic [1:0]       map_rdata, map_wdata;

  always #5 clk = ~clk;

  man_move_ctrl #(.START_POS(6'd9), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_pos(load_pos),
    .move_req(move_req), .move_dir(move_dir),
`ifdef MAN_UNDO_EN
    .undo_req(undo_req),
`endif
    .busy(busy), .move_done(move_done), .moved(moved), .pushed(pushed),
    .man(man), .step_cnt(step_cnt), .push_cnt(push_cnt),
    .map_addr(map_addr), .map_rd_en(map_rd_en), .map_rdata(map_rdata),
    .map_wr_en(map_wr_en), .map_wdata(map_wdata)
  );

  // map RAM with one-cycle read latency, plus access logs
  logic [1:0] ram [64];
  logic [5:0] rd_log [$];
  logic [7:0] wr_log [$];
  logic       poke_en;
  logic [5:0] poke_addr;
  logic [1:0] poke_val;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= 2'b00;
      map_rdata <= 2'b00;
    end else begin
      if (poke_en) ram[poke_addr] <= poke_val;
      if (map_rd_en) begin
        map_rdata <= ram[map_addr];
        rd_log.push_back(map_addr);
      end
      if (map_wr_en) begin
        ram[map_addr] <= map_wdata;
        wr_log.push_back({map_addr, map_wdata});
      end
    end
  end

  // model: expected outputs switch from old to new values at edge ex_D
  logic [1:0] gmap [64];
  int         ex_A = -100, ex_D = -100;
  logic       ex_pulse = 1'b0, ex_moved = 1'b0, ex_pushed = 1'b0;
  logic [5:0] ex_old_man = 6'd9, ex_new_man = 6'd9;
  int         ex_old_step = 0, ex_new_step = 0, ex_old_push = 0, ex_new_push = 0;
  logic [5:0] exp_rd [$];
  logic [7:0] exp_wr [$];
  int         vectors = 0, miscompares = 0;
  logic       chk_on = 1'b0;
`ifdef MAN_UNDO_EN
  logic       rec_valid = 1'b0, rec_pushed = 1'b0;
  logic [5:0] rec_prev = 6'd0, rec_n = 6'd0, rec_b = 6'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int   k;
      logic settled, e_done;
      k       = cyc;
      settled = (k >= ex_D);
      e_done  = ex_pulse && (k == ex_D);
      check("busy", busy, (k >= ex_A) && (k < ex_D));
      check("move_done", move_done, e_done);
      check("man", man, settled ? ex_new_man : ex_old_man);
      check("step_cnt", step_cnt, settled ? ex_new_step : ex_old_step);
      check("push_cnt", push_cnt, settled ? ex_new_push : ex_old_push);
      check("rd_wr_excl", map_rd_en & map_wr_en, 0);
      if (e_done) begin
        check("moved", moved, ex_moved);
        check("pushed", pushed, ex_pushed);
      end
    end
  end

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic logic in_grid(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  task automatic model_move(input logic [1:0] d);
    int r, c, dr, dc, nr, nc, n, b, lat;
    logic mv, ps;
    r  = int'(ex_new_man[5:3]);
    c  = int'(ex_new_man[2:0]);
    dr = (d == 2'd0) ? -1 : (d == 2'd1) ? 1 : 0;
    dc = (d == 2'd2) ? -1 : (d == 2'd3) ? 1 : 0;
    nr = r + dr; nc = c + dc;
    n = 0; b = 0; lat = 0; mv = 1'b0; ps = 1'b0;
    exp_rd.delete(); exp_wr.delete();
    if (in_grid(nr, nc)) begin
      n = nr * 8 + nc;
      exp_rd.push_back(6'(n));
      lat = 2;
      if (gmap[n] == 2'b00) mv = 1'b1;
      else if (gmap[n] == 2'b10 && in_grid(nr + dr, nc + dc)) begin
        b = (nr + dr) * 8 + (nc + dc);
        exp_rd.push_back(6'(b));
        lat = 4;
        if (gmap[b] == 2'b00) begin
          mv = 1'b1; ps = 1'b1; lat = 6;
          exp_wr.push_back({6'(b), 2'b10});
          exp_wr.push_back({6'(n), 2'b00});
        end
      end
    end
    ex_old_man = ex_new_man; ex_old_step = ex_new_step; ex_old_push = ex_new_push;
    ex_A = cyc + 1; ex_D = ex_A + lat;
    ex_pulse = 1'b1; ex_moved = mv; ex_pushed = ps;
    if (mv) begin
      ex_new_man  = 6'(n);
      ex_new_step = sat(ex_new_step + 1);
`ifdef MAN_UNDO_EN
      rec_valid = 1'b1; rec_prev = ex_old_man; rec_pushed = ps;
      rec_n = 6'(n); rec_b = 6'(b);
`endif
    end
    if (ps) ex_new_push = sat(ex_new_push + 1);
  endtask

  task automatic apply_and_check(input string tag);
    logic [7:0] e;
    int diff;
    for (int i = 0; i < exp_wr.size(); i++) begin
      e = exp_wr[i];
      gmap[e[7:2]] = e[1:0];
    end
    check({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
    check({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check({tag, "_wr_addr_data"}, wr_log[i], exp_wr[i]);
    diff = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== gmap[i]) diff++;
    check({tag, "_map_cells_differing"}, diff, 0);
  endtask

  task automatic set_cell(input int a, input logic [1:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = 6'(a); poke_val = v;
    gmap[a] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // poke: re-request during the busy window, which must be ignored
  task automatic do_move(input string tag, input logic [1:0] d, input logic poke);
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    model_move(d);
    move_req = 1'b1; move_dir = d;
    @(negedge clk);
    move_req = poke; move_dir = ~d;
    @(negedge clk);
    move_req = 1'b0;
    while (cyc <= ex_D) @(negedge clk);
    apply_and_check(tag);
  endtask

  task automatic model_load(input logic [5:0] pos);
    ex_old_man = ex_new_man; ex_old_step = ex_new_step; ex_old_push = ex_new_push;
    ex_new_man = pos; ex_new_step = 0; ex_new_push = 0;
    ex_A = cyc + 1; ex_D = cyc + 1; ex_pulse = 1'b0;
`ifdef MAN_UNDO_EN
    rec_valid = 1'b0;
`endif
  endtask

  task automatic do_load(input logic [5:0] pos, input logic with_move);
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    exp_rd.delete(); exp_wr.delete();
    model_load(pos);
    load = 1'b1; load_pos = pos; move_req = with_move; move_dir = 2'd0;
    @(negedge clk);
    load = 1'b0; move_req = 1'b0;
    repeat (3) @(negedge clk);
    apply_and_check("load");
  endtask

  task automatic push_with_load(input logic [5:0] pos);
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    model_move(2'd3);
    move_req = 1'b1; move_dir = 2'd3;
    @(negedge clk);
    move_req = 1'b0;
    repeat (3) @(negedge clk);
    // CHK2 cycle of the push: abort here, before any write is issued
    ex_new_man = pos; ex_new_step = 0; ex_new_push = 0;
    ex_D = cyc + 1; ex_pulse = 1'b0;
    exp_wr.delete();
`ifdef MAN_UNDO_EN
    rec_valid = 1'b0;
`endif
    load = 1'b1; load_pos = pos;
    @(negedge clk);
    load = 1'b0;
    check("abort_busy_low", busy, 0);
    repeat (4) @(negedge clk);
    apply_and_check("abort");
  endtask

`ifdef MAN_UNDO_EN
  task automatic do_undo(input string tag);
    @(negedge clk);
    rd_log.delete(); wr_log.delete();
    exp_rd.delete(); exp_wr.delete();
    if (rec_valid) begin
      ex_old_man = ex_new_man; ex_old_step = ex_new_step; ex_old_push = ex_new_push;
      ex_A = cyc + 1; ex_D = ex_A + (rec_pushed ? 2 : 0);
      ex_pulse = 1'b1; ex_moved = 1'b1; ex_pushed = rec_pushed;
      ex_new_man  = rec_prev;
      ex_new_step = (ex_new_step > 0) ? ex_new_step - 1 : 0;
      if (rec_pushed) begin
        ex_new_push = (ex_new_push > 0) ? ex_new_push - 1 : 0;
        exp_wr.push_back({rec_b, 2'b00});
        exp_wr.push_back({rec_n, 2'b10});
      end
      rec_valid = 1'b0;
    end
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    repeat (3) @(negedge clk);
    apply_and_check(tag);
  endtask
`endif

  initial begin
    rst_n = 1'b0; load = 1'b0; load_pos = 6'd0; move_req = 1'b0; move_dir = 2'd0;
    poke_en = 1'b0; poke_addr = 6'd0; poke_val = 2'b00;
`ifdef MAN_UNDO_EN
    undo_req = 1'b0;
`endif
    for (int i = 0; i < 64; i++) gmap[i] = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_man", man, 9);
    check("rst_step", step_cnt, 0);
    check("rst_push", push_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", move_done, 0);
    check("rst_moved_pushed", {moved, pushed}, 0);
    check("rst_strobes", {map_rd_en, map_wr_en}, 0);
    check("rst_addr_wdata", {map_addr, map_wdata}, 0);
    rst_n = 1'b1; chk_on = 1'b1;

    do_move("up_free", 2'd0, 1'b0);
    check("pin_free_latency", ex_D - ex_A, 2);
    check("pin_up_man", man, 1);
    check("pin_up_step", step_cnt, 1);
    check("pin_up_rd_addr", (rd_log.size() > 0) ? rd_log[0] : 6'h3f, 1);

    do_move("down_free", 2'd1, 1'b0);
    set_cell(10, 2'b01);
    do_move("right_wall", 2'd3, 1'b1);
    check("pin_wall_man", man, 9);
    check("pin_wall_step", step_cnt, 2);
    check("pin_wall_no_write", wr_log.size(), 0);

    set_cell(10, 2'b10);
    do_move("push", 2'd3, 1'b0);
    check("pin_push_latency", ex_D - ex_A, 6);
    check("pin_push_man", man, 10);
    check("pin_push_cnt", push_cnt, 1);
    check("pin_push_ram11", ram[11], 2'b10);
    check("pin_push_ram10", ram[10], 2'b00);

    set_cell(2, 2'b11);
    do_move("code11_wall", 2'd0, 1'b0);
    set_cell(18, 2'b10);
    set_cell(26, 2'b01);
    do_move("box_then_wall", 2'd1, 1'b1);

    do_load(6'd9, 1'b0);
    set_cell(8, 2'b10);
    do_move("box_at_edge", 2'd2, 1'b0);
    do_load(6'd8, 1'b0);
    do_move("offgrid_left", 2'd2, 1'b0);
    check("pin_offgrid_latency", ex_D - ex_A, 0);
    do_load(6'd63, 1'b0);
    do_move("offgrid_down", 2'd1, 1'b0);
    check("pin_offgrid_no_ram", rd_log.size() + wr_log.size(), 0);
    do_load(6'd27, 1'b1);
    check("pin_load_wins_man", man, 27);

    do_load(6'd9, 1'b0);
    set_cell(10, 2'b10);
    set_cell(11, 2'b00);
    push_with_load(6'd20);
    check("pin_abort_man", man, 20);
    check("pin_abort_cnts", {step_cnt, push_cnt}, 0);

    do_load(6'd42, 1'b0);
    for (int i = 0; i < 9; i++) do_move("saturate", (i % 2) ? 2'd3 : 2'd2, 1'b0);
    check("pin_step_saturated", step_cnt, CNT_MAX);

`ifdef MAN_UNDO_EN
    do_load(6'd9, 1'b0);
    do_move("undo_setup_push", 2'd3, 1'b0);
    do_undo("undo_push");
    check("pin_undo_man", man, 9);
    check("pin_undo_cnts", {step_cnt, push_cnt}, 0);
    check("pin_undo_ram10", ram[10], 2'b10);
    check("pin_undo_ram11", ram[11], 2'b00);
    do_undo("undo_none");
    do_move("undo_setup_free", 2'd0, 1'b0);
    do_undo("undo_free");
    check("pin_undo_free_man", man, 9);
`endif

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
